writeback_stage: RTL and testbench

//  Final (WB) stage of the 5-stage RV32I pipeline; consumer end of the memory-stage output interface.

---
 rtl/writeback_stage_if.sv | 46 ++++
 rtl/writeback_stage.sv | 120 ++++++++++++
 tb/tb_writeback_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Memory-stage -> writeback-stage bus, plus the writeback outputs.
// The outputs are the register-file write port, the forwarding bus, the error pulse
// and the retire count.
interface writeback_stage_if #(
   parameter int unsigned DWIDTH       = 32,
   parameter int unsigned AWIDTH       = 5,
   parameter int unsigned FUNCT_WIDTH  = 3,
   parameter int unsigned CNT_WIDTH    = 32,
   parameter int unsigned OPCODE_WIDTH = 11
);
   logic                    wb_i_ce;
   logic                    wb_i_stall;
   logic                    wb_i_flush;
   logic [OPCODE_WIDTH-1:0] wb_i_opcode;
   logic [FUNCT_WIDTH-1:0]  wb_i_funct3;
   logic [AWIDTH-1:0]       wb_i_rd_addr;
   logic [DWIDTH-1:0]       wb_i_rd_data;
   logic                    wb_i_rd_we;
   logic [DWIDTH-1:0]       wb_i_load_data;
   logic [1:0]              wb_i_addr_lsb;

   logic                    wb_o_rf_we;
   logic [AWIDTH-1:0]       wb_o_rf_addr;
   logic [DWIDTH-1:0]       wb_o_rf_data;
   logic                    wb_o_fwd_valid;
   logic [AWIDTH-1:0]       wb_o_fwd_addr;
   logic [DWIDTH-1:0]       wb_o_fwd_data;
   logic                    wb_o_err;
   logic [CNT_WIDTH-1:0]    wb_o_retired;

   // Memory stage side: drives the instruction, observes writeback results.
   modport master (
      output wb_i_ce, wb_i_stall, wb_i_flush, wb_i_opcode, wb_i_funct3, wb_i_rd_addr,
             wb_i_rd_data, wb_i_rd_we, wb_i_load_data, wb_i_addr_lsb,
      input  wb_o_rf_we, wb_o_rf_addr, wb_o_rf_data, wb_o_fwd_valid, wb_o_fwd_addr,
             wb_o_fwd_data, wb_o_err, wb_o_retired
   );

   // Writeback stage side.
   modport slave (
      input  wb_i_ce, wb_i_stall, wb_i_flush, wb_i_opcode, wb_i_funct3, wb_i_rd_addr,
             wb_i_rd_data, wb_i_rd_we, wb_i_load_data, wb_i_addr_lsb,
      output wb_o_rf_we, wb_o_rf_addr, wb_o_rf_data, wb_o_fwd_valid, wb_o_fwd_addr,
             wb_o_fwd_data, wb_o_err, wb_o_retired
   );
endinterface

// File: rtl/writeback_stage.sv
// RV32I writeback stage.
// It registers the memory-stage result and formats load data by funct3 and byte offset.
// It issues one register-file write per retired instruction, mirrored on the forwarding bus,
// and counts retired instructions.
module writeback_stage #(
   parameter int unsigned DWIDTH       = 32,
   parameter int unsigned AWIDTH       = 5,
   parameter int unsigned FUNCT_WIDTH  = 3,
   parameter int unsigned CNT_WIDTH    = 32,
   parameter int unsigned OPCODE_WIDTH = 11,
   parameter int unsigned LOAD         = 2
) (
   input logic              wb_clk,
   input logic              wb_rst,
   writeback_stage_if.slave wb
);

   logic                 valid_q, valid_d;
   logic                 new_q, new_d;     // first output cycle of the held instruction
   logic                 rd_we_q, rd_we_d;
   logic                 err_q, err_d;
   logic [AWIDTH-1:0]    rd_addr_q, rd_addr_d;
   logic [DWIDTH-1:0]    rf_data_q, rf_data_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;

   logic [7:0]           load_byte;
   logic [15:0]          load_half;
   logic [DWIDTH-1:0]    load_fmt;
   logic                 load_err;
   logic                 is_load;

   // Format the incoming load word and flag illegal/misaligned accesses.
   always_comb begin
      load_byte = wb.wb_i_load_data[8*wb.wb_i_addr_lsb +: 8];
      load_half = wb.wb_i_load_data[16*wb.wb_i_addr_lsb[1] +: 16];
      load_fmt  = '0;
      load_err  = 1'b0;
      case (wb.wb_i_funct3)
         3'b000: load_fmt = {{(DWIDTH-8){load_byte[7]}}, load_byte};
         3'b100: load_fmt = {{(DWIDTH-8){1'b0}}, load_byte};
         3'b001, 3'b101: begin
            if (wb.wb_i_addr_lsb[0]) begin
               load_err = 1'b1;
            end else if (wb.wb_i_funct3[2]) begin
               load_fmt = {{(DWIDTH-16){1'b0}}, load_half};
            end else begin
               load_fmt = {{(DWIDTH-16){load_half[15]}}, load_half};
            end
         end
         3'b010: begin
            if (wb.wb_i_addr_lsb != 2'b00) load_err = 1'b1;
            else                           load_fmt = wb.wb_i_load_data;
         end
         default: load_err = 1'b1;
      endcase
   end

   assign is_load = wb.wb_i_opcode[LOAD];

   // Pipeline-register next state: flush beats stall, stall holds, ce captures, else bubble.
   always_comb begin
      valid_d   = valid_q;
      new_d     = 1'b0;
      rd_we_d   = rd_we_q;
      err_d     = err_q;
      rd_addr_d = rd_addr_q;
      rf_data_d = rf_data_q;
      retired_d = retired_q;
      if (wb.wb_i_flush) begin
         valid_d = 1'b0;
      end else if (wb.wb_i_stall) begin
         valid_d = valid_q;
      end else if (wb.wb_i_ce) begin
         valid_d   = 1'b1;
         new_d     = 1'b1;
         rd_we_d   = wb.wb_i_rd_we;
         err_d     = is_load & load_err;
         rd_addr_d = wb.wb_i_rd_addr;
         rf_data_d = is_load ? load_fmt : wb.wb_i_rd_data;
         // Counted at capture so the count is already updated in the output cycle.
         retired_d = retired_q + CNT_WIDTH'(1);
      end else begin
         valid_d = 1'b0;
      end
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         valid_q   <= 1'b0;
         new_q     <= 1'b0;
         rd_we_q   <= 1'b0;
         err_q     <= 1'b0;
         rd_addr_q <= '0;
         rf_data_q <= '0;
         retired_q <= '0;
      end else begin
         valid_q   <= valid_d;
         new_q     <= new_d;
         rd_we_q   <= rd_we_d;
         err_q     <= err_d;
         rd_addr_q <= rd_addr_d;
         rf_data_q <= rf_data_d;
         retired_q <= retired_d;
      end
   end

   logic write_en;
   assign write_en = valid_q & new_q & rd_we_q & (|rd_addr_q) & ~err_q;

   assign wb.wb_o_rf_we     = write_en;
   assign wb.wb_o_rf_addr   = rd_addr_q;
   assign wb.wb_o_rf_data   = rf_data_q;
   assign wb.wb_o_fwd_valid = write_en;
   assign wb.wb_o_fwd_addr  = rd_addr_q;
   assign wb.wb_o_fwd_data  = rf_data_q;
   assign wb.wb_o_err       = valid_q & new_q & err_q;
   assign wb.wb_o_retired   = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases followed by random traffic,
// compared against a behavioural model of the stage.
module tb_writeback_stage;

   localparam int unsigned CW = 4;  // small counter so wrap-around is reachable

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_stage_if #(.CNT_WIDTH(CW)) wb_if ();

   writeback_stage #(.CNT_WIDTH(CW)) dut (
      .wb_clk (clk),
      .wb_rst (rst_n),
      .wb     (wb_if.slave)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Model state.
   bit          m_valid, m_new, m_we, m_err;
   bit [4:0]    m_addr;
   bit [31:0]   m_data;
   int unsigned m_cnt;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Load result and error flag straight from the load-formatting table.
   function automatic void model_fmt(input bit [31:0] ld, input bit [2:0] f3, input int lsb,
                                     output bit [31:0] d, output bit e);
      int unsigned bv, hv;
      bv = (ld >> (8 * lsb)) & 32'hFF;
      hv = (ld >> (16 * (lsb / 2))) & 32'hFFFF;
      d = 0;
      e = 0;
      case (f3)
         3'd0: d = (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
         3'd4: d = bv;
         3'd1: if (lsb % 2 != 0) e = 1; else d = (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
         3'd5: if (lsb % 2 != 0) e = 1; else d = hv;
         3'd2: if (lsb != 0) e = 1; else d = ld;
         default: e = 1;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_new = 0; m_we = 0; m_err = 0; m_addr = 0; m_data = 0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string tag);
      bit exp_we;
      exp_we = m_new && m_we && (m_addr != 0) && !m_err;
      check_val({tag, ".rf_we"}, 32'(wb_if.wb_o_rf_we), 32'(exp_we));
      check_val({tag, ".fwd_valid"}, 32'(wb_if.wb_o_fwd_valid), 32'(exp_we));
      check_val({tag, ".err"}, 32'(wb_if.wb_o_err), 32'(m_new && m_err));
      check_val({tag, ".retired"}, 32'(wb_if.wb_o_retired), m_cnt % (1 << CW));
      if (m_valid) begin
         check_val({tag, ".rf_addr"}, 32'(wb_if.wb_o_rf_addr), 32'(m_addr));
         check_val({tag, ".rf_data"}, wb_if.wb_o_rf_data, m_data);
         check_val({tag, ".fwd_addr"}, 32'(wb_if.wb_o_fwd_addr), 32'(m_addr));
         check_val({tag, ".fwd_data"}, wb_if.wb_o_fwd_data, m_data);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, ".rf_we"}, 32'(wb_if.wb_o_rf_we), 0);
      check_val({tag, ".rf_addr"}, 32'(wb_if.wb_o_rf_addr), 0);
      check_val({tag, ".rf_data"}, wb_if.wb_o_rf_data, 0);
      check_val({tag, ".fwd_valid"}, 32'(wb_if.wb_o_fwd_valid), 0);
      check_val({tag, ".fwd_addr"}, 32'(wb_if.wb_o_fwd_addr), 0);
      check_val({tag, ".fwd_data"}, wb_if.wb_o_fwd_data, 0);
      check_val({tag, ".err"}, 32'(wb_if.wb_o_err), 0);
      check_val({tag, ".retired"}, 32'(wb_if.wb_o_retired), 0);
   endtask

   // Apply one cycle of stimulus, advance the model at the edge, check 1 time unit later.
   task automatic step(input string tag, input bit ce, input bit stall, input bit flush,
                       input bit is_ld, input bit [2:0] f3, input bit [4:0] a,
                       input bit [31:0] d, input bit we, input bit [31:0] ldd,
                       input bit [1:0] lsb);
      bit [31:0] fd;
      bit        fe;
      wb_if.wb_i_ce        = ce;
      wb_if.wb_i_stall     = stall;
      wb_if.wb_i_flush     = flush;
      wb_if.wb_i_opcode    = is_ld ? 11'b000_0000_0100 : 11'b000_0000_0001;
      wb_if.wb_i_funct3    = f3;
      wb_if.wb_i_rd_addr   = a;
      wb_if.wb_i_rd_data   = d;
      wb_if.wb_i_rd_we     = we;
      wb_if.wb_i_load_data = ldd;
      wb_if.wb_i_addr_lsb  = lsb;
      @(posedge clk);
      m_new = 0;
      if (flush) begin
         m_valid = 0;
      end else if (stall) begin
         // hold
      end else if (ce) begin
         model_fmt(ldd, f3, int'(lsb), fd, fe);
         m_valid = 1;
         m_new   = 1;
         m_we    = we;
         m_addr  = a;
         m_err   = is_ld && fe;
         m_data  = is_ld ? fd : d;
         m_cnt   = (m_cnt + 1) % (1 << CW);
      end else begin
         m_valid = 0;
      end
      #1;
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 2'd0);
   endtask

   initial begin
      model_reset();
      step("rst_in", 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 2'd0);
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // ALU write
      step("alu", 1, 0, 0, 0, 3'd0, 5'd5, 32'h1234_5678, 1, 32'd0, 2'd0);
      check_val("alu.data_direct", wb_if.wb_o_rf_data, 32'h1234_5678);
      // Byte loads
      step("lb3", 1, 0, 0, 1, 3'd0, 5'd6, 32'd0, 1, 32'h80FF_7F80, 2'd3);
      check_val("lb3.direct", wb_if.wb_o_rf_data, 32'hFFFF_FF80);
      step("lbu3", 1, 0, 0, 1, 3'd4, 5'd6, 32'd0, 1, 32'h80FF_7F80, 2'd3);
      check_val("lbu3.direct", wb_if.wb_o_rf_data, 32'h0000_0080);
      step("lb1", 1, 0, 0, 1, 3'd0, 5'd6, 32'd0, 1, 32'h80FF_7F80, 2'd1);
      check_val("lb1.direct", wb_if.wb_o_rf_data, 32'h0000_007F);
      // Half loads, misaligned word
      step("lh2", 1, 0, 0, 1, 3'd1, 5'd7, 32'd0, 1, 32'h8001_0000, 2'd2);
      check_val("lh2.direct", wb_if.wb_o_rf_data, 32'hFFFF_8001);
      step("lw2", 1, 0, 0, 1, 3'd2, 5'd7, 32'd0, 1, 32'h8001_0000, 2'd2);
      check_val("lw2.err_direct", 32'(wb_if.wb_o_err), 1);
      step("ill", 1, 0, 0, 1, 3'd3, 5'd8, 32'd0, 1, 32'h1111_2222, 2'd0);
      // Capture then stall three cycles, then flush during stall
      step("cap", 1, 0, 0, 0, 3'd0, 5'd9, 32'hCAFE_0009, 1, 32'd0, 2'd0);
      for (int i = 0; i < 3; i++) step("stall", 1, 1, 0, 0, 3'd0, 5'd10, 32'h5, 1, 32'd0, 2'd0);
      step("flush", 1, 1, 1, 0, 3'd0, 5'd10, 32'h5, 1, 32'd0, 2'd0);
      idle("post_flush");
      // Faulting load then stall: err not repeated
      step("lhu_mis", 1, 0, 0, 1, 3'd5, 5'd3, 32'd0, 1, 32'hABCD_1234, 2'd1);
      step("err_stall", 0, 1, 0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 2'd0);
      // x0 never written
      step("x0", 1, 0, 0, 0, 3'd0, 5'd0, 32'hDEAD_BEEF, 1, 32'd0, 2'd0);
      // Counter wrap: retire until the count wraps through zero
      for (int i = 0; i < (1 << CW) + 2; i++)
         step("wrap", 1, 0, 0, 0, 3'd0, 5'(i + 1), 32'(i), 1, 32'd0, 2'd0);
      // Async reset mid-cycle
      step("pre_rst", 1, 0, 0, 0, 3'd0, 5'd4, 32'h4444_4444, 1, 32'd0, 2'd0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      // Reset while stalled: pending instruction is discarded
      step("pend", 1, 0, 0, 0, 3'd0, 5'd12, 32'h0C0C_0C0C, 1, 32'd0, 2'd0);
      step("pend_st", 0, 1, 0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 2'd0);
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle("after_rst_stall");
      idle("after_rst_stall2");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bit        ce, st, fl, ld, we;
         bit [2:0]  f3;
         bit [4:0]  a;
         bit [1:0]  lsb;
         ce  = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 4) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         ld  = $urandom_range(0, 1) != 0;
         we  = ($urandom_range(0, 5) != 0);
         f3  = 3'($urandom_range(0, 7));
         a   = 5'($urandom_range(0, 31));
         lsb = 2'($urandom_range(0, 3));
         step("rand", ce, st, fl, ld, f3, a, $urandom, we, $urandom, lsb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
